bomb_scheduler: RTL and testbench

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomb_pkg.sv | 23 ++
 rtl/bomb_scheduler_if.sv | 36 +++
 rtl/bomb_slot.sv | 69 ++++++
 rtl/bomb_scheduler.sv | 144 ++++++++++++++
 tb/tb_bomb_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types and defaults for the bomb scheduler slice.
//   slot_state_t - life cycle of one bomb slot
//   owner_t      - owner encoding used on explode_owner (0 = P1, 1 = P2)
//   GRID_CELLS   - width of the occupancy map (16x16 grid, cell = 16*y+x)
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2,
    SLOT_FIRING  = 2'd3
  } slot_state_t;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_t;

  localparam int unsigned GRID_CELLS     = 256;
  localparam int unsigned NUM_SLOTS_DEF  = 8;
  localparam int unsigned FUSE_TICKS_DEF = 3;

endpackage

// File: rtl/bomb_scheduler_if.sv
// bomb_scheduler_if: player requests, tick, explosion handshake and status.
//   master : drives tick, placement requests, limits, explode_ready
//   slave  : the scheduler; drives occupancy map, counts, explosion, slots_full
interface bomb_scheduler_if;
  import bomb_pkg::*;

  logic                  tick;
  logic                  p1_set_bomb;
  logic                  p2_set_bomb;
  logic [7:0]            p1_coordinate;
  logic [7:0]            p2_coordinate;
  logic [2:0]            bomb_max_1;
  logic [2:0]            bomb_max_2;
  logic                  explode_ready;
  logic [GRID_CELLS-1:0] bomb_wall_o;
  logic [2:0]            bomb_num_1;
  logic [2:0]            bomb_num_2;
  logic                  explode_valid;
  logic [7:0]            explode_coord;
  logic                  explode_owner;
  logic                  slots_full;

  modport master (
    output tick, p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
           bomb_max_1, bomb_max_2, explode_ready,
    input  bomb_wall_o, bomb_num_1, bomb_num_2, explode_valid,
           explode_coord, explode_owner, slots_full
  );

  modport slave (
    input  tick, p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
           bomb_max_1, bomb_max_2, explode_ready,
    output bomb_wall_o, bomb_num_1, bomb_num_2, explode_valid,
           explode_coord, explode_owner, slots_full
  );
endinterface

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot, FREE -> ARMED -> PENDING -> FIRING -> FREE.
//   clk, rst  : clock, synchronous active-high reset
//   i_alloc   : load coord/owner and arm (only honoured while FREE)
//   i_coord   : cell to arm, i_owner: placing player
//   i_tick    : fuse time base, counted only while ARMED
//   i_fire    : PENDING slot selected for presentation
//   i_free    : explosion handshake completed for this FIRING slot
//   o_state, o_coord, o_owner : registered slot contents
module bomb_slot import bomb_pkg::*; #(
  parameter int unsigned FUSE_TICKS = FUSE_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_alloc,
  input  logic [7:0]  i_coord,
  input  owner_t      i_owner,
  input  logic        i_tick,
  input  logic        i_fire,
  input  logic        i_free,
  output slot_state_t o_state,
  output logic [7:0]  o_coord,
  output owner_t      o_owner
);
  slot_state_t r_state, w_state_nxt;
  logic [7:0]  r_coord, w_coord_nxt;
  owner_t      r_owner, w_owner_nxt;
  logic [3:0]  r_timer, w_timer_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_FREE;
      r_coord <= '0;
      r_owner <= OWNER_P1;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_coord <= w_coord_nxt;
      r_owner <= w_owner_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Allocation only happens from FREE, so the allocating cycle never ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_coord_nxt = r_coord;
    w_owner_nxt = r_owner;
    w_timer_nxt = r_timer;
    unique case (r_state)
      SLOT_FREE: if (i_alloc) begin
        w_state_nxt = SLOT_ARMED;
        w_coord_nxt = i_coord;
        w_owner_nxt = i_owner;
        w_timer_nxt = 4'(FUSE_TICKS);
      end
      SLOT_ARMED: if (i_tick) begin
        w_timer_nxt = r_timer - 4'd1;
        if (r_timer == 4'd1) w_state_nxt = SLOT_PENDING;
      end
      SLOT_PENDING: if (i_fire) w_state_nxt = SLOT_FIRING;
      SLOT_FIRING:  if (i_free) w_state_nxt = SLOT_FREE;
      default: ;
    endcase
  end

  assign o_state = r_state;
  assign o_coord = r_coord;
  assign o_owner = r_owner;
endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: two-player bomb placement over NUM_SLOTS shared fuse slots.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bomb_scheduler_if (requests, tick, limits,
//              explosion valid/ready handshake, occupancy map, counts, full)
// Allocation, arbitration and the explosion output register live here;
// per-slot state and fuse timers live in bomb_slot.
module bomb_scheduler import bomb_pkg::*; #(
  parameter int unsigned NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int unsigned FUSE_TICKS = FUSE_TICKS_DEF
) (
  input logic             clk,
  input logic             rst,
  bomb_scheduler_if.slave bus
);
  slot_state_t           w_state      [NUM_SLOTS];
  logic [7:0]            w_slot_coord [NUM_SLOTS];
  owner_t                w_slot_owner [NUM_SLOTS];
  logic [7:0]            w_alloc_coord[NUM_SLOTS];
  owner_t                w_alloc_owner[NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  w_alloc, w_fire, w_free_slot;
  logic [NUM_SLOTS-1:0]  w_lo_oh, w_hi_oh, w_pend_oh;
  logic                  w_any_free, w_two_free, w_any_pend;
  logic [7:0]            w_pend_coord;
  owner_t                w_pend_owner;

  logic [GRID_CELLS-1:0] r_wall, w_wall_nxt;
  logic [2:0]            r_num1, r_num2;
  logic                  r_valid;
  logic [7:0]            r_coord;
  owner_t                r_owner, r_prio;

  logic w_hs, w_elig1, w_elig2, w_conflict, w_acc1, w_acc2, w_dec1, w_dec2;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_alloc (w_alloc[g]),
      .i_coord (w_alloc_coord[g]),
      .i_owner (w_alloc_owner[g]),
      .i_tick  (bus.tick),
      .i_fire  (w_fire[g]),
      .i_free  (w_free_slot[g]),
      .o_state (w_state[g]),
      .o_coord (w_slot_coord[g]),
      .o_owner (w_slot_owner[g])
    );
  end

  // Lowest and second-lowest FREE slot, lowest PENDING slot (one-hot).
  always_comb begin
    w_lo_oh      = '0;
    w_hi_oh      = '0;
    w_pend_oh    = '0;
    w_any_free   = 1'b0;
    w_two_free   = 1'b0;
    w_any_pend   = 1'b0;
    w_pend_coord = '0;
    w_pend_owner = OWNER_P1;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (w_state[i] == SLOT_FREE) begin
        if (!w_any_free) begin
          w_lo_oh[i] = 1'b1;
          w_any_free = 1'b1;
        end else if (!w_two_free) begin
          w_hi_oh[i] = 1'b1;
          w_two_free = 1'b1;
        end
      end
      if (w_state[i] == SLOT_PENDING && !w_any_pend) begin
        w_pend_oh[i] = 1'b1;
        w_any_pend   = 1'b1;
        w_pend_coord = w_slot_coord[i];
        w_pend_owner = w_slot_owner[i];
      end
    end
  end

  assign w_hs    = r_valid && bus.explode_ready;
  assign w_elig1 = bus.p1_set_bomb && (r_num1 < bus.bomb_max_1) &&
                   !r_wall[bus.p1_coordinate] && w_any_free;
  assign w_elig2 = bus.p2_set_bomb && (r_num2 < bus.bomb_max_2) &&
                   !r_wall[bus.p2_coordinate] && w_any_free;
  assign w_conflict = w_elig1 && w_elig2 &&
                      ((bus.p1_coordinate == bus.p2_coordinate) || !w_two_free);
  assign w_acc1 = w_elig1 && !(w_conflict && r_prio == OWNER_P2);
  assign w_acc2 = w_elig2 && !(w_conflict && r_prio == OWNER_P1);
  assign w_dec1 = w_hs && r_owner == OWNER_P1 && r_num1 != 3'd0;
  assign w_dec2 = w_hs && r_owner == OWNER_P2 && r_num2 != 3'd0;

  // P1 takes the lowest FREE slot when accepted; P2 takes the next one up
  // in that case, otherwise the lowest.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      w_alloc[i]       = (w_acc1 && w_lo_oh[i]) ||
                         (w_acc2 && (w_acc1 ? w_hi_oh[i] : w_lo_oh[i]));
      w_alloc_coord[i] = (w_acc1 && w_lo_oh[i]) ? bus.p1_coordinate : bus.p2_coordinate;
      w_alloc_owner[i] = (w_acc1 && w_lo_oh[i]) ? OWNER_P1 : OWNER_P2;
      w_fire[i]        = !r_valid && w_pend_oh[i];
      w_free_slot[i]   = w_hs && (w_state[i] == SLOT_FIRING);
    end
  end

  always_comb begin
    w_wall_nxt = r_wall;
    if (w_hs)   w_wall_nxt[r_coord] = 1'b0;
    if (w_acc1) w_wall_nxt[bus.p1_coordinate] = 1'b1;
    if (w_acc2) w_wall_nxt[bus.p2_coordinate] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wall  <= '0;
      r_num1  <= '0;
      r_num2  <= '0;
      r_valid <= 1'b0;
      r_coord <= '0;
      r_owner <= OWNER_P1;
      r_prio  <= OWNER_P1;
    end else begin
      r_wall <= w_wall_nxt;
      r_num1 <= r_num1 + {2'b00, w_acc1} - {2'b00, w_dec1};
      r_num2 <= r_num2 + {2'b00, w_acc2} - {2'b00, w_dec2};
      if (w_conflict) r_prio <= (r_prio == OWNER_P1) ? OWNER_P2 : OWNER_P1;
      // Handshake wins over loading, so a new explosion appears one cycle
      // after explode_valid has dropped.
      if (w_hs) begin
        r_valid <= 1'b0;
      end else if (!r_valid && w_any_pend) begin
        r_valid <= 1'b1;
        r_coord <= w_pend_coord;
        r_owner <= w_pend_owner;
      end
    end
  end

  assign bus.bomb_wall_o   = r_wall;
  assign bus.bomb_num_1    = r_num1;
  assign bus.bomb_num_2    = r_num2;
  assign bus.explode_valid = r_valid;
  assign bus.explode_coord = r_coord;
  assign bus.explode_owner = r_owner;
  assign bus.slots_full    = !w_any_free;
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: directed vectors for bomb_scheduler (8 slots, fuse 3).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bomb_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bomb_scheduler_if bus();

  bomb_scheduler #(.NUM_SLOTS(8), .FUSE_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wb(input logic [7:0] c);
    return {31'b0, bus.bomb_wall_o[c]};
  endfunction

  function automatic logic [31:0] n1();
    return {29'b0, bus.bomb_num_1};
  endfunction

  function automatic logic [31:0] n2();
    return {29'b0, bus.bomb_num_2};
  endfunction

  function automatic logic [31:0] vld();
    return {31'b0, bus.explode_valid};
  endfunction

  function automatic logic [31:0] crd();
    return {24'b0, bus.explode_coord};
  endfunction

  function automatic logic [31:0] own();
    return {31'b0, bus.explode_owner};
  endfunction

  function automatic logic [31:0] full();
    return {31'b0, bus.slots_full};
  endfunction

  function automatic logic [31:0] anywall();
    return {31'b0, |bus.bomb_wall_o};
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick cycle followed by one quiet cycle.
  task automatic tickn(input int unsigned n);
    repeat (n) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic req(input logic s1, input logic [7:0] c1,
                     input logic s2, input logic [7:0] c2);
    bus.p1_set_bomb   = s1;
    bus.p1_coordinate = c1;
    bus.p2_set_bomb   = s2;
    bus.p2_coordinate = c2;
    cyc(1);
    bus.p1_set_bomb = 1'b0;
    bus.p2_set_bomb = 1'b0;
  endtask

  task automatic hs();
    bus.explode_ready = 1'b1;
    cyc(1);
    bus.explode_ready = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0;  bus.explode_ready = 1'b0;
    bus.p1_set_bomb = 1'b0;  bus.p2_set_bomb = 1'b0;
    bus.p1_coordinate = '0;  bus.p2_coordinate = '0;
    bus.bomb_max_1 = 3'd7;   bus.bomb_max_2 = 3'd7;
    rst = 1'b1;
    cyc(2);
    chk("rst_wall", anywall(), 0);
    chk("rst_num1", n1(), 0);
    chk("rst_num2", n2(), 0);
    chk("rst_valid", vld(), 0);
    chk("rst_full", full(), 0);
    rst = 1'b0;
    cyc(1);

    // Single placement, fuse and explosion.
    bus.bomb_max_1 = 3'd1;
    req(1, 8'h11, 0, 8'h00);
    chk("p1_wall11", wb(8'h11), 1);
    chk("p1_num1", n1(), 1);
    req(1, 8'h12, 0, 8'h00);
    chk("max_wall12", wb(8'h12), 0);
    chk("max_num1", n1(), 1);
    tickn(2);
    chk("fuse2_valid", vld(), 0);
    tickn(1);
    chk("fuse3_valid", vld(), 1);
    chk("fuse3_coord", crd(), 32'h11);
    chk("fuse3_owner", own(), 0);
    hs();
    chk("hs_valid", vld(), 0);
    chk("hs_wall11", wb(8'h11), 0);
    chk("hs_num1", n1(), 0);
    bus.bomb_max_1 = 3'd7;

    // Same-cell contention: priority alternates.
    req(1, 8'h22, 1, 8'h22);
    chk("arb1_num1", n1(), 1);
    chk("arb1_num2", n2(), 0);
    tickn(3);
    chk("arb1_owner", own(), 0);
    hs();
    req(1, 8'h22, 1, 8'h22);
    chk("arb2_num1", n1(), 0);
    chk("arb2_num2", n2(), 1);
    tickn(3);
    chk("arb2_owner", own(), 1);
    chk("arb2_coord", crd(), 32'h22);
    hs();

    // Backpressure while a second bomb becomes pending.
    req(1, 8'h30, 0, 8'h00);
    tickn(1);
    req(0, 8'h00, 1, 8'h31);
    tickn(2);
    chk("bp_valid0", vld(), 1);
    chk("bp_coord0", crd(), 32'h30);
    tickn(1);
    cyc(8);
    chk("bp_valid_hold", vld(), 1);
    chk("bp_coord_hold", crd(), 32'h30);
    chk("bp_owner_hold", own(), 0);
    hs();
    chk("bp_gap_valid", vld(), 0);
    cyc(1);
    chk("bp_next_valid", vld(), 1);
    chk("bp_next_coord", crd(), 32'h31);
    chk("bp_next_owner", own(), 1);
    hs();

    // Fill all eight slots.
    req(1, 8'h40, 1, 8'h41);
    req(1, 8'h42, 1, 8'h43);
    req(1, 8'h44, 1, 8'h45);
    chk("fill_full6", full(), 0);
    req(1, 8'h46, 1, 8'h47);
    chk("fill_full8", full(), 1);
    chk("fill_num1", n1(), 4);
    chk("fill_num2", n2(), 4);
    req(1, 8'h50, 0, 8'h00);
    chk("ninth_wall50", wb(8'h50), 0);
    chk("ninth_num1", n1(), 4);
    tickn(3);
    chk("fill_coord", crd(), 32'h40);
    bus.p2_set_bomb = 1'b1;  bus.p2_coordinate = 8'h51;
    hs();
    bus.p2_set_bomb = 1'b0;
    chk("free_full", full(), 0);
    chk("hscyc_wall51", wb(8'h51), 0);
    chk("hscyc_num2", n2(), 4);
    chk("free_num1", n1(), 3);
    req(1, 8'h50, 0, 8'h00);
    chk("reuse_wall50", wb(8'h50), 1);
    chk("reuse_num1", n1(), 4);
    chk("reuse_full", full(), 1);
    chk("reuse_coord", crd(), 32'h41);

    // Reset with live bombs and an explosion on display.
    chk("prerst_valid", vld(), 1);
    rst = 1'b1;
    bus.p1_set_bomb = 1'b1;  bus.p1_coordinate = 8'h70;
    cyc(1);
    rst = 1'b0;
    bus.p1_set_bomb = 1'b0;
    chk("mrst_wall", anywall(), 0);
    chk("mrst_num1", n1(), 0);
    chk("mrst_num2", n2(), 0);
    chk("mrst_valid", vld(), 0);
    chk("mrst_coord", crd(), 0);
    chk("mrst_owner", own(), 0);
    chk("mrst_full", full(), 0);
    tickn(4);
    cyc(3);
    chk("mrst_quiet_valid", vld(), 0);
    chk("mrst_quiet_wall", anywall(), 0);

    // Limit reached, then same-cycle increment and decrement.
    bus.bomb_max_1 = 3'd2;
    req(1, 8'h60, 0, 8'h00);
    tickn(1);
    req(1, 8'h61, 0, 8'h00);
    req(1, 8'h62, 0, 8'h00);
    chk("lim_num1", n1(), 2);
    chk("lim_wall62", wb(8'h62), 0);
    tickn(2);
    chk("lim_coord", crd(), 32'h60);
    bus.p1_set_bomb = 1'b1;  bus.p1_coordinate = 8'h62;
    hs();
    bus.p1_set_bomb = 1'b0;
    chk("limhs_num1", n1(), 1);
    chk("limhs_wall62", wb(8'h62), 0);
    req(1, 8'h62, 0, 8'h00);
    chk("lim_after_num1", n1(), 2);
    chk("lim_after_wall62", wb(8'h62), 1);
    bus.bomb_max_1 = 3'd3;
    tickn(1);
    chk("incdec_coord", crd(), 32'h61);
    bus.p1_set_bomb = 1'b1;  bus.p1_coordinate = 8'h63;
    hs();
    bus.p1_set_bomb = 1'b0;
    chk("incdec_num1", n1(), 2);
    chk("incdec_wall61", wb(8'h61), 0);
    chk("incdec_wall63", wb(8'h63), 1);

    // Lowered limit blocks placements only; occupied cell is refused.
    bus.bomb_max_1 = 3'd1;
    req(1, 8'h64, 1, 8'h62);
    chk("lower_num1", n1(), 2);
    chk("lower_wall64", wb(8'h64), 0);
    chk("lower_wall62", wb(8'h62), 1);
    chk("occ_num2", n2(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
